// File: rtl/wb_bram_ctrl.sv
// Wishbone slave for the user-project BRAM with fixed, programmable wait-state latency.
// Optional build macro WB_BRAM_RANGE_CHK_EN adds an adr[31:24]==BASE_HI request qualifier.
//
// state | meaning
// IDLE  | waiting for cyc&stb; request operands captured on acceptance
// WAIT  | counting down wait states; cyc drop aborts without write or ack
// ACK   | one-cycle acknowledge; write committed / read data registered on entry
module wb_bram_ctrl #(
  parameter int          ADDR_W  = 10,
  parameter int          DELAYS  = 10,
  parameter logic [7:0]  BASE_HI = 8'h38
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        bram_busy_o
);

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  localparam logic [7:0] DELAYS_C = 8'(DELAYS);

  state_t              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [3:0]          sel_q, sel_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [31:0]         wdat_q, wdat_d;
  logic [31:0]         rdat_q, rdat_d;

  logic [31:0]         mem_q [2**ADDR_W];

  logic                in_range;
  logic                req;
  logic                commit;
  logic                op_we;
  logic [3:0]          op_sel;
  logic [ADDR_W-1:0]   op_idx;
  logic [31:0]         op_dat;
  logic                mem_we;
  logic                unused_ok;

`ifdef WB_BRAM_RANGE_CHK_EN
  assign in_range = (wbs_adr_i[31:24] == BASE_HI);
`else
  assign in_range = 1'b1;
`endif

  assign unused_ok = ^{wbs_adr_i[31:ADDR_W+2], wbs_adr_i[1:0], BASE_HI};

  assign req = wbs_cyc_i & wbs_stb_i & in_range;

  // With zero wait states the commit happens on the capture edge, so use live inputs.
  always_comb begin
    op_we  = we_q;
    op_sel = sel_q;
    op_idx = idx_q;
    op_dat = wdat_q;
    if (state_q == IDLE) begin
      op_we  = wbs_we_i;
      op_sel = wbs_sel_i;
      op_idx = wbs_adr_i[ADDR_W+1:2];
      op_dat = wbs_dat_i;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    sel_d   = sel_q;
    idx_d   = idx_q;
    wdat_d  = wdat_q;
    rdat_d  = 32'h0;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          we_d   = wbs_we_i;
          sel_d  = wbs_sel_i;
          idx_d  = wbs_adr_i[ADDR_W+1:2];
          wdat_d = wbs_dat_i;
          if (DELAYS_C == 8'd0) begin
            state_d = ACK;
            commit  = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = DELAYS_C;
          end
        end
      end
      WAIT: begin
        if (!wbs_cyc_i) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end else if (cnt_q == 8'd1) begin
          state_d = ACK;
          cnt_d   = 8'd0;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (commit && !op_we) rdat_d = mem_q[op_idx];
  end

  assign mem_we = commit & op_we & ~wb_rst_i;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      we_q    <= 1'b0;
      sel_q   <= 4'h0;
      idx_q   <= '0;
      wdat_q  <= 32'h0;
      rdat_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      idx_q   <= idx_d;
      wdat_q  <= wdat_d;
      rdat_q  <= rdat_d;
    end
  end

  // RAM contents survive reset; only the commit itself is gated.
  always_ff @(posedge wb_clk_i) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (op_sel[i]) mem_q[op_idx][8*i +: 8] <= op_dat[8*i +: 8];
      end
    end
  end

  assign wbs_ack_o   = (state_q == ACK) & ~wb_rst_i;
  assign wbs_dat_o   = rdat_q;
  assign bram_busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_wb_bram_ctrl.sv
// Directed bench for wb_bram_ctrl: one instance with DELAYS=10, one with DELAYS=0.
module tb_wb_bram_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst, a_cyc, a_stb, a_we, a_ack, a_busy;
  logic [3:0]  a_sel;
  logic [31:0] a_adr, a_dat, a_dat_o;

  logic        b_rst, b_cyc, b_stb, b_we, b_ack, b_busy;
  logic [3:0]  b_sel;
  logic [31:0] b_adr, b_dat, b_dat_o;

  wb_bram_ctrl #(.ADDR_W(10), .DELAYS(10), .BASE_HI(8'h38)) u_dut_a (
    .wb_clk_i(clk), .wb_rst_i(a_rst), .wbs_cyc_i(a_cyc), .wbs_stb_i(a_stb),
    .wbs_we_i(a_we), .wbs_sel_i(a_sel), .wbs_adr_i(a_adr), .wbs_dat_i(a_dat),
    .wbs_ack_o(a_ack), .wbs_dat_o(a_dat_o), .bram_busy_o(a_busy)
  );

  wb_bram_ctrl #(.ADDR_W(10), .DELAYS(0), .BASE_HI(8'h38)) u_dut_b (
    .wb_clk_i(clk), .wb_rst_i(b_rst), .wbs_cyc_i(b_cyc), .wbs_stb_i(b_stb),
    .wbs_we_i(b_we), .wbs_sel_i(b_sel), .wbs_adr_i(b_adr), .wbs_dat_i(b_dat),
    .wbs_ack_o(b_ack), .wbs_dat_o(b_dat_o), .bram_busy_o(b_busy)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Full transfer on instance A; dirty flags ack/data activity outside the ack cycle.
  task automatic a_xfer(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                        input logic [31:0] dat, output logic [31:0] rdata, output int lat,
                        output logic dirty, output logic busy_seen);
    a_cyc = 1'b1; a_stb = 1'b1; a_we = we; a_sel = sel; a_adr = adr; a_dat = dat;
    lat = 0; dirty = 1'b0; rdata = 32'h0; busy_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      lat++;
      if (i == 0) busy_seen = a_busy;
      if (a_ack) break;
      if (a_dat_o != 32'h0) dirty = 1'b1;
    end
    rdata = a_dat_o;
    a_cyc = 1'b0; a_stb = 1'b0;
    @(negedge clk);
    if (a_ack || a_dat_o != 32'h0 || a_busy) dirty = 1'b1;
  endtask

  logic [31:0] rd;
  int          lat;
  logic        dirty, bsy, seen;
  logic [31:0] pre [4];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    pre[0] = 32'h0102_0304; pre[1] = 32'hA5A5_5A5A;
    pre[2] = 32'hFFFF_0000; pre[3] = 32'h1357_9BDF;
    a_rst = 1'b1; a_cyc = 1'b0; a_stb = 1'b0; a_we = 1'b0; a_sel = 4'h0;
    a_adr = 32'h0; a_dat = 32'h0;
    b_rst = 1'b1; b_cyc = 1'b0; b_stb = 1'b0; b_we = 1'b0; b_sel = 4'h0;
    b_adr = 32'h0; b_dat = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_ack", {31'h0, a_ack}, 32'h0);
    chk("rst_dat", a_dat_o, 32'h0);
    chk("rst_busy", {31'h0, a_busy}, 32'h0);
    a_rst = 1'b0; b_rst = 1'b0;
    @(negedge clk);

    a_xfer(1'b1, 4'hF, 32'h3800_0004, 32'hDEAD_BEEF, rd, lat, dirty, bsy);
    chk("wr_latency", lat, 11);
    chk("wr_busy", {31'h0, bsy}, 32'h1);
    chk("wr_clean", {31'h0, dirty}, 32'h0);
    a_xfer(1'b0, 4'hF, 32'h3800_0004, 32'h0, rd, lat, dirty, bsy);
    chk("rd_latency", lat, 11);
    chk("rd_data", rd, 32'hDEAD_BEEF);
    chk("rd_clean", {31'h0, dirty}, 32'h0);

    a_xfer(1'b1, 4'hF, 32'h3800_0010, 32'h1122_3344, rd, lat, dirty, bsy);
    a_xfer(1'b1, 4'b0101, 32'h3800_0010, 32'hAABB_CCDD, rd, lat, dirty, bsy);
    a_xfer(1'b0, 4'b0001, 32'h3800_0010, 32'h0, rd, lat, dirty, bsy);
    chk("lane_data", rd, 32'h11BB_33DD);

    a_cyc = 1'b1; a_stb = 1'b1; a_we = 1'b1; a_sel = 4'hF;
    a_adr = 32'h3800_0010; a_dat = 32'h55AA_55AA;
    repeat (3) @(negedge clk);
    chk("abort_busy", {31'h0, a_busy}, 32'h1);
    a_cyc = 1'b0; a_stb = 1'b0;
    @(negedge clk);
    chk("abort_busy_fall", {31'h0, a_busy}, 32'h0);
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (a_ack) seen = 1'b1;
    end
    chk("abort_noack", {31'h0, seen}, 32'h0);
    a_xfer(1'b0, 4'hF, 32'h3800_0010, 32'h0, rd, lat, dirty, bsy);
    chk("abort_keep", rd, 32'h11BB_33DD);

    a_cyc = 1'b1; a_stb = 1'b1; a_we = 1'b1; a_sel = 4'hF;
    a_adr = 32'h3800_0004; a_dat = 32'h1234_5678;
    repeat (5) @(negedge clk);
    a_rst = 1'b1;
    @(negedge clk);
    chk("rstwait_ack", {31'h0, a_ack}, 32'h0);
    chk("rstwait_busy", {31'h0, a_busy}, 32'h0);
    a_cyc = 1'b0; a_stb = 1'b0; a_rst = 1'b0;
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (a_ack) seen = 1'b1;
    end
    chk("rstwait_noack", {31'h0, seen}, 32'h0);
    a_xfer(1'b0, 4'hF, 32'h3800_0004, 32'h0, rd, lat, dirty, bsy);
    chk("rstwait_keep", rd, 32'hDEAD_BEEF);

    a_cyc = 1'b1; a_stb = 1'b1; a_we = 1'b0; a_adr = 32'h3800_0004;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (a_ack) break;
    end
    chk("rstack_seen", {31'h0, a_ack}, 32'h1);
    a_rst = 1'b1;
    #1;
    chk("rstack_mask", {31'h0, a_ack}, 32'h0);
    @(negedge clk);
    chk("rstack_busy", {31'h0, a_busy}, 32'h0);
    a_cyc = 1'b0; a_stb = 1'b0; a_rst = 1'b0;
    @(negedge clk);

`ifdef WB_BRAM_RANGE_CHK_EN
    a_cyc = 1'b1; a_stb = 1'b1; a_we = 1'b1; a_sel = 4'hF;
    a_adr = 32'h3000_0000; a_dat = 32'h0BAD_0BAD;
    seen = 1'b0; bsy = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (a_ack) seen = 1'b1;
      if (a_busy) bsy = 1'b1;
    end
    chk("oor_noack", {31'h0, seen}, 32'h0);
    chk("oor_nobusy", {31'h0, bsy}, 32'h0);
    a_cyc = 1'b0; a_stb = 1'b0;
    @(negedge clk);
    a_xfer(1'b0, 4'hF, 32'h3800_0000, 32'h0, rd, lat, dirty, bsy);
    chk("inr_latency", lat, 11);
`else
    a_xfer(1'b1, 4'hF, 32'h3000_0020, 32'hCAFE_F00D, rd, lat, dirty, bsy);
    chk("alias_wr_latency", lat, 11);
    a_xfer(1'b0, 4'hF, 32'h3800_1020, 32'h0, rd, lat, dirty, bsy);
    chk("alias_rd_data", rd, 32'hCAFE_F00D);
`endif

    for (int i = 0; i < 4; i++) begin
      b_cyc = 1'b1; b_stb = 1'b1; b_we = 1'b1; b_sel = 4'hF;
      b_adr = 32'h3800_0000 + 32'(4 * i); b_dat = pre[i];
      @(negedge clk);
      chk("b_wr_ack", {31'h0, b_ack}, 32'h1);
      b_cyc = 1'b0; b_stb = 1'b0;
      @(negedge clk);
      chk("b_wr_gap", {31'h0, b_ack}, 32'h0);
    end
    b_cyc = 1'b1; b_stb = 1'b1; b_we = 1'b0; b_adr = 32'h3800_0000;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i % 2 == 0) begin
        chk("b2b_ack", {31'h0, b_ack}, 32'h1);
        chk("b2b_data", b_dat_o, pre[i/2]);
        b_adr = 32'h3800_0000 + 32'(4 * (i/2 + 1));
      end else begin
        chk("b2b_gap_ack", {31'h0, b_ack}, 32'h0);
        chk("b2b_gap_dat", b_dat_o, 32'h0);
      end
    end
    b_cyc = 1'b0; b_stb = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
